// File: rtl/as_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package   : as_arb_pkg
// Purpose   : Shared widths, output-register state encoding and the
//             round-robin pick function used by the add/sub arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
package as_arb_pkg;

  localparam int AS_IN_W  = 30;  // operand width of the add/sub unit
  localparam int AS_OUT_W = 31;  // result width (one guard bit, never overflows)
  localparam int MAX_REQ  = 16;  // largest supported requester count
  localparam int PICK_W   = 4;   // index width able to address MAX_REQ

  // Output register state
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // Returns the first set bit of valid, searching ptr+1, ptr+2, ... modulo n.
  // Requires ptr < n. ptr + i never exceeds 31, so a 5-bit index suffices and
  // a single conditional subtract performs the wrap.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PICK_W-1:0]  ptr,
    input logic [PICK_W:0]    n
  );
    logic [PICK_W-1:0] pick;
    logic              found;
    logic [PICK_W:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = {1'b0, ptr} + (PICK_W+1)'(i);
      if (idx >= n) idx = idx - n;
      if (!found && ((PICK_W+1)'(i) <= n) && valid[idx[PICK_W-1:0]]) begin
        pick  = idx[PICK_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/as_rr_arbiter_as.sv
`default_nettype none
// ============================================================================
// Module    : as_rr_arbiter_as
// Purpose   : 30-bit two's complement add/sub unit. Operands are sign
//             extended to 31 bits so the result can never overflow.
// Ports     : a_i   [29:0] operand A
//             b_i   [29:0] operand B
//             sub_i        1 = A-B, 0 = A+B
//             out_o [30:0] sext(A) +/- sext(B)
// Revision  : 1.0 - initial release
// ============================================================================
module as_rr_arbiter_as
  import as_arb_pkg::*;
(
  input  logic [AS_IN_W-1:0]  a_i,
  input  logic [AS_IN_W-1:0]  b_i,
  input  logic                sub_i,
  output logic [AS_OUT_W-1:0] out_o
);

  logic [AS_OUT_W-1:0] w_a_ext;
  logic [AS_OUT_W-1:0] w_b_ext;

  assign w_a_ext = {a_i[AS_IN_W-1], a_i};
  assign w_b_ext = {b_i[AS_IN_W-1], b_i};
  assign out_o   = sub_i ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

endmodule
`default_nettype wire

// File: rtl/as_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : as_rr_arbiter
// Purpose   : Shares one 30-bit add/sub unit among NREQ requesters with
//             round-robin arbitration. One operation per cycle is accepted
//             into a single-entry result register returned on a valid/ready
//             port tagged with the requester id.
// Ports     : clk, rst                 clock, async active-high reset
//             req_valid_i/req_ready_o  per-requester handshake (ready one-hot)
//             req_a_i/req_b_i          packed operands, requester i at [30*i +: 30]
//             req_sub_i                per-requester subtract select
//             res_valid_o/res_ready_i  result handshake
//             res_data_o               31-bit result
//             res_id_o                 id of the producing requester
// Revision  : 1.0 - initial release
// ============================================================================
module as_rr_arbiter
  import as_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*AS_IN_W-1:0] req_a_i,
  input  logic [NREQ*AS_IN_W-1:0] req_b_i,
  input  logic [NREQ-1:0]         req_sub_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [AS_OUT_W-1:0]     res_data_o,
  output logic [ID_W-1:0]         res_id_o
);

  logic [0:0]          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [AS_OUT_W-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;

  logic                w_drain;
  logic                w_slot_free;
  logic                w_accept;
  logic [ID_W-1:0]     w_grant;
  logic [AS_IN_W-1:0]  w_a;
  logic [AS_IN_W-1:0]  w_b;
  logic                w_sub;
  logic [AS_OUT_W-1:0] w_as_out;

  assign res_valid_o = (state_q == FULL);
  assign res_data_o  = res_data_q;
  assign res_id_o    = res_id_q;

  assign w_drain     = res_valid_o & res_ready_i;
  assign w_slot_free = ~res_valid_o | w_drain;
  // Held off while rst is asserted so no requester sees ready during reset.
  assign w_accept    = w_slot_free & (|req_valid_i) & ~rst;

  assign w_grant = ID_W'(rr_pick(MAX_REQ'(req_valid_i), PICK_W'(rr_ptr_q),
                                 (PICK_W+1)'(NREQ)));

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready_o[gi] = w_accept && (w_grant == ID_W'(gi));
  end

  // Operand mux in front of the shared unit
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_a   = req_a_i[i*AS_IN_W +: AS_IN_W];
        w_b   = req_b_i[i*AS_IN_W +: AS_IN_W];
        w_sub = req_sub_i[i];
      end
    end
  end

  as_rr_arbiter_as u_as (
    .a_i   (w_a),
    .b_i   (w_b),
    .sub_i (w_sub),
    .out_o (w_as_out)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    case (state_q)
      EMPTY:   if (w_accept) state_d = FULL;
      FULL:    if (w_drain && !w_accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    // Result register and pointer only move on accept; a drain alone leaves
    // the last result visible on res_data/res_id.
    if (w_accept) begin
      rr_ptr_d   = w_grant;
      res_data_d = w_as_out;
      res_id_d   = w_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= ID_W'(NREQ - 1);
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_as_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_as_rr_arbiter
// Purpose   : Directed and scoreboarded testbench for as_rr_arbiter (NREQ=4).
// Revision  : 1.0 - initial release
// ============================================================================
module tb_as_rr_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*30-1:0] req_a;
  logic [NREQ*30-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              res_valid;
  logic              res_ready;
  logic [30:0]       res_data;
  logic [ID_W-1:0]   res_id;

  int vec_cnt = 0;
  int err_cnt = 0;

  as_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_sub_i   (req_sub),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_id_o    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (no checking)
  task automatic set_req(input int idx, input logic [29:0] a, input logic [29:0] b,
                         input logic sub);
    req_a[idx*30 +: 30] = a;
    req_b[idx*30 +: 30] = b;
    req_sub[idx]        = sub;
    req_valid[idx]      = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; res_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111; res_ready = 1'b1;
    #1;
    vec_cnt++; if (res_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %0b want 0", res_valid); end
    vec_cnt++; if (res_data !== 31'd0) begin err_cnt++; $display("FAIL reset_data got %h want 0", res_data); end
    vec_cnt++; if (res_id !== 2'd0) begin err_cnt++; $display("FAIL reset_id got %0d want 0", res_id); end
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    res_ready = 1'b1;
    set_req(0, 30'd5, 30'd3, 1'b0);
    #1;
    vec_cnt++; if (req_ready !== 4'b0001) begin err_cnt++; $display("FAIL basic_ready got %b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    vec_cnt++; if (res_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid got %0b want 1", res_valid); end
    vec_cnt++; if (res_data !== 31'h0000_0008) begin err_cnt++; $display("FAIL basic_data got %h want 00000008", res_data); end
    vec_cnt++; if (res_id !== 2'd0) begin err_cnt++; $display("FAIL basic_id got %0d want 0", res_id); end
    @(posedge clk); #1;
    // drained with no new accept: result fields hold their last value
    vec_cnt++; if (res_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_valid got %0b want 0", res_valid); end
    vec_cnt++; if (res_data !== 31'h0000_0008) begin err_cnt++; $display("FAIL drain_hold got %h want 00000008", res_data); end
  endtask

  task automatic test_arith();
    logic [29:0] ta [3];
    logic [29:0] tb [3];
    logic        ts [3];
    logic [30:0] te [3];
    ta[0] = 30'd3;          tb[0] = 30'd5;          ts[0] = 1'b1; te[0] = 31'h7FFF_FFFE;
    ta[1] = 30'h1FFF_FFFF;  tb[1] = 30'h1FFF_FFFF;  ts[1] = 1'b0; te[1] = 31'h3FFF_FFFE;
    ta[2] = 30'h2000_0000;  tb[2] = 30'd1;          ts[2] = 1'b1; te[2] = 31'h5FFF_FFFF;
    res_ready = 1'b1;
    set_req(2, ta[0], tb[0], ts[0]);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k < 2) set_req(2, ta[k+1], tb[k+1], ts[k+1]);
      else req_valid = '0;
      vec_cnt++; if (res_valid !== 1'b1) begin err_cnt++; $display("FAIL arith%0d_valid got %0b want 1", k, res_valid); end
      vec_cnt++; if (res_data !== te[k]) begin err_cnt++; $display("FAIL arith%0d_data got %h want %h", k, res_data, te[k]); end
      vec_cnt++; if (res_id !== 2'd2) begin err_cnt++; $display("FAIL arith%0d_id got %0d want 2", k, res_id); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    apply_reset();
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 30'(100 * i), 30'(i), 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      vec_cnt++; if (res_valid !== 1'b1) begin err_cnt++; $display("FAIL rr%0d_valid got %0b want 1", k, res_valid); end
      vec_cnt++; if (res_id !== 2'(k % 4)) begin err_cnt++; $display("FAIL rr%0d_id got %0d want %0d", k, res_id, k % 4); end
      vec_cnt++; if (res_data !== 31'(101 * (k % 4))) begin err_cnt++; $display("FAIL rr%0d_data got %0d want %0d", k, res_data, 101 * (k % 4)); end
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    // pointer is 3 after the round robin run
    res_ready = 1'b0;
    set_req(1, 30'd40, 30'd2, 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    set_req(2, 30'd7, 30'd9, 1'b0);
    set_req(3, 30'd1, 30'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL stall%0d_ready got %b want 0000", k, req_ready); end
      vec_cnt++; if (res_valid !== 1'b1 || res_data !== 31'd38 || res_id !== 2'd1) begin
        err_cnt++; $display("FAIL stall%0d_hold got v=%0b d=%0d id=%0d want v=1 d=38 id=1", k, res_valid, res_data, res_id);
      end
      if (k == 2) req_valid[3] = 1'b0;  // requester 3 withdraws before being served
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #1;
    vec_cnt++; if (req_ready !== 4'b0100) begin err_cnt++; $display("FAIL refill_ready got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    vec_cnt++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 31'd16) begin
      err_cnt++; $display("FAIL refill_res got v=%0b d=%0d id=%0d want v=1 d=16 id=2", res_valid, res_data, res_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    res_ready = 1'b0;
    set_req(1, 30'd11, 30'd22, 1'b0);
    @(posedge clk); #1;
    vec_cnt++; if (res_valid !== 1'b1) begin err_cnt++; $display("FAIL midop_setup got %0b want 1", res_valid); end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++; if (res_valid !== 1'b0 || res_data !== 31'd0 || res_id !== 2'd0) begin
      err_cnt++; $display("FAIL midop_rst got v=%0b d=%0d id=%0d want 0 0 0", res_valid, res_data, res_id);
    end
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL midop_ready got %b want 0000", req_ready); end
    @(posedge clk); #1;
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL midop_ready2 got %b want 0000", req_ready); end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [29:0] ra [NREQ];
    logic [29:0] rb [NREQ];
    logic        rs [NREQ];
    logic        hold [NREQ];
    int          waitc [NREQ];
    logic [32:0] q [$];
    logic [32:0] exp;
    logic        mdl_full;
    int          mdl_ptr;
    int          g;
    logic        slot_free, acc;
    logic [3:0]  exp_ready;
    logic [30:0] sum;
    apply_reset();
    mdl_full = 1'b0;
    mdl_ptr  = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin hold[i] = 1'b0; waitc[i] = 0; end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hold[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          ra[i] = 30'($urandom); rb[i] = 30'($urandom); rs[i] = 1'($urandom);
        end
        req_a[i*30 +: 30] = ra[i];
        req_b[i*30 +: 30] = rb[i];
        req_sub[i]        = rs[i];
      end
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      slot_free = !mdl_full || res_ready;
      acc = slot_free && (req_valid != 0);
      g = 0;
      for (int j = NREQ; j >= 1; j--) if (req_valid[(mdl_ptr + j) % NREQ]) g = (mdl_ptr + j) % NREQ;
      exp_ready = acc ? (4'b0001 << g) : 4'b0000;
      vec_cnt++; if (res_valid !== mdl_full) begin err_cnt++; $display("FAIL rnd%0d_valid got %0b want %0b", c, res_valid, mdl_full); end
      vec_cnt++; if (req_ready !== exp_ready) begin err_cnt++; $display("FAIL rnd%0d_ready got %b want %b", c, req_ready, exp_ready); end
      if (mdl_full && res_ready) begin
        if (q.size() == 0) begin
          err_cnt++; $display("FAIL rnd%0d_underflow got result want none", c);
        end else begin
          exp = q.pop_front();
          vec_cnt++; if ({res_id, res_data} !== exp[32:0]) begin
            err_cnt++; $display("FAIL rnd%0d_result got id=%0d d=%h want id=%0d d=%h", c, res_id, res_data, exp[32:31], exp[30:0]);
          end
        end
      end
      if (acc) begin
        sum = rs[g] ? ({ra[g][29], ra[g]} - {rb[g][29], rb[g]}) : ({ra[g][29], ra[g]} + {rb[g][29], rb[g]});
        q.push_back({2'(g), sum});
        for (int i = 0; i < NREQ; i++) begin
          if (i == g) waitc[i] = 0;
          else if (req_valid[i]) begin
            waitc[i]++;
            vec_cnt++; if (waitc[i] >= NREQ) begin err_cnt++; $display("FAIL rnd%0d_starve req%0d waited %0d want <%0d", c, i, waitc[i], NREQ); end
          end
        end
        mdl_ptr = g;
      end
      mdl_full = acc || (mdl_full && !res_ready);
      for (int i = 0; i < NREQ; i++) hold[i] = req_valid[i] && !exp_ready[i];
      @(posedge clk); #1;
    end
    req_valid = '0;
    res_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_sub = '0;
    test_reset();
    test_basic();
    test_arith();
    test_round_robin();
    test_stall();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
